// File: rtl/spu_es1_op_serializer.sv
// rtl/spu_es1_op_serializer.sv - parallel word to framed serial stream (sync, data, CRC-8)
module spu_es1_op_serializer #(
  parameter int         WIDTH  = 1024,
  parameter logic [7:0] SYNC   = 8'hA5,
  parameter             DEVICE = "ULTRASCALE_PLUS"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_dout,
  output logic             m_frame,
  output logic             m_last,
  output logic             busy
);

  localparam int CW = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CRC} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [7:0]       crc;
  logic             accept;

  if ($bits(DEVICE) > 0) begin : g_device_tag
  end

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign s_ready = !reset && (state == S_IDLE || (state == S_CRC && cnt == '0));
  assign accept  = s_valid && s_ready;
  assign busy    = (state != S_IDLE);

  // State names the section whose bit is currently on m_dout; cnt is that bit's index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      crc     <= 8'h00;
      m_dout  <= 1'b0;
      m_frame <= 1'b0;
      m_last  <= 1'b0;
    end else if (cke) begin
      m_last <= 1'b0;
      if (accept) begin
        state   <= S_SYNC;
        cnt     <= CW'(7);
        shreg   <= s_data;
        crc     <= 8'h00;
        m_dout  <= SYNC[7];
        m_frame <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            m_dout  <= 1'b0;
            m_frame <= 1'b0;
          end
          S_SYNC: begin
            if (cnt == '0) begin
              state  <= S_DATA;
              cnt    <= CW'(WIDTH - 1);
              m_dout <= shreg[WIDTH-1];
              shreg  <= {shreg[WIDTH-2:0], 1'b0};
              crc    <= crc_step(crc, shreg[WIDTH-1]);
            end else begin
              cnt    <= cnt - 1'b1;
              m_dout <= SYNC[cnt[2:0] - 3'd1];
            end
          end
          S_DATA: begin
            if (cnt == '0) begin
              state  <= S_CRC;
              cnt    <= CW'(7);
              m_dout <= crc[7];
              crc    <= {crc[6:0], 1'b0};
            end else begin
              cnt    <= cnt - 1'b1;
              m_dout <= shreg[WIDTH-1];
              shreg  <= {shreg[WIDTH-2:0], 1'b0};
              crc    <= crc_step(crc, shreg[WIDTH-1]);
            end
          end
          S_CRC: begin
            if (cnt == '0) begin
              state   <= S_IDLE;
              m_dout  <= 1'b0;
              m_frame <= 1'b0;
            end else begin
              cnt    <= cnt - 1'b1;
              m_dout <= crc[7];
              crc    <= {crc[6:0], 1'b0};
              m_last <= (cnt == CW'(1));
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spu_es1_op_serializer.md
SPU_ES1_OP_SERIALIZER -- requirements
Module: spu_es1_op_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, number of payload data bits per frame (legal range 8..4096).
REQ-002 SHALL have parameter SYNC, default 8'hA5, 8-bit frame sync pattern.
REQ-003 SHALL have parameter DEVICE, default "ULTRASCALE_PLUS", target device name; no functional effect.
REQ-004 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cke  input  1  clock enable; low freezes all state and outputs.
REQ-007 SHALL have port s_data  input  WIDTH  parallel word to transmit.
REQ-008 SHALL have port s_valid  input  1  s_data valid.
REQ-009 SHALL have port s_ready  output  1  block can accept a word.
REQ-010 SHALL have port m_dout  output  1  serial bit stream, registered.
REQ-011 SHALL have port m_frame  output  1  high while m_dout carries a frame bit, registered.
REQ-012 SHALL have port m_last  output  1  high on the final CRC bit of a frame, registered.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL accept a word on a rising edge where s_valid && s_ready && cke; s_data captured into an internal WIDTH-bit shift register at that edge.
REQ-015 SHALL use states IDLE, SYNC, DATA, CRC; IDLE->SYNC on accept; SYNC->DATA after 8 bits; DATA->CRC after WIDTH bits; CRC->IDLE after 8 bits, or CRC->SYNC on accept during the last CRC bit.
REQ-016 SHALL emit each frame as exactly 16+WIDTH consecutive cke-qualified cycles: 8 SYNC bits MSB first, then WIDTH data bits MSB first (s_data[WIDTH-1] first), then 8 CRC bits MSB first.
REQ-017 SHALL present the first SYNC bit on m_dout in the first cke-qualified cycle after the accept edge (latency 1 enabled cycle).
REQ-018 SHALL compute CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, serially over data bits in transmit order: crc <= {crc[6:0],1'b0} ^ ((crc[7]^bit) ? 8'h07 : 8'h00).
REQ-019 SHALL reset the CRC accumulator to 0x00 on every accept, including back-to-back accepts.
REQ-020 SHALL drive s_ready = !reset && (state==IDLE || (state==CRC && bit counter at last CRC bit)); s_ready is the only combinational output.
REQ-021 SHALL, on back-to-back accept in the last CRC bit cycle, start the next frame's SYNC bit 7 in the immediately following enabled cycle with no gap, m_frame staying high.
REQ-022 SHALL hold m_frame=0, m_last=0, m_dout=0 in IDLE.
REQ-023 SHALL assert m_last for exactly one enabled cycle per frame, coincident with CRC bit 0.
REQ-024 SHALL, when cke=0, hold state, counters, shift register, CRC and all registered outputs unchanged; s_valid is ignored.
REQ-025 SHALL size the bit counter as $clog2(WIDTH) or 3 bits, whichever is larger; no counter wrap beyond the frame length.
REQ-026 SHALL ignore s_data/s_valid changes while busy and s_ready=0; the captured word is unaffected.

Reset
REQ-027 SHALL, on a clk edge with reset=1 (regardless of cke), force state IDLE, counters 0, CRC 0x00, shift register 0, m_dout=0, m_frame=0, m_last=0, busy=0.
REQ-028 SHALL hold s_ready=0 while reset is high, and s_ready=1 in the first cycle after reset deasserts.
REQ-029 SHALL abort any frame in progress on reset; no further bits of it are emitted.

Verification (WIDTH=8, SYNC=8'hA5)
REQ-030 SHALL verify s_data=8'h01 accepted -> m_dout stream 10100101 00000001 00000111 on 24 consecutive cycles, m_frame high throughout, m_last only on the 24th.
REQ-031 SHALL verify s_data=8'hFF -> CRC bits 11110011 (0xF3); s_data=8'h00 -> CRC 0x00.
REQ-032 SHALL verify back-to-back: s_valid held high with 8'h01 then 8'hFF -> 48 contiguous frame bits, s_ready high only on cycle 24 of the first frame.
REQ-033 SHALL verify cke toggled 1/0 every cycle during an 8'h01 frame -> identical bit sequence at enabled cycles, outputs stable on disabled cycles.
REQ-034 SHALL verify reset asserted at data bit 3 -> next cycle m_frame=0, busy=0, m_dout=0; then new word 8'hFF yields a complete, correct frame with CRC 0xF3.
REQ-035 SHALL verify s_data changed mid-frame while s_ready=0 -> transmitted data bits equal the originally accepted word.
